det_collector: RTL
==================

// Module: det_collector
// PURPOSE
//   Downstream of the HOG+SVM top. Captures per-window SVM outputs (o_valid, is_person, result, sw_id),
//   queues positive detections {sw_id,result} in a show-ahead FIFO for the host/bbox logic, and keeps
//   per-frame statistics: detection count and best (max) score with its window index.
// PARAMETERS
//   FEA_I    4     integer bits of SVM score
//   FEA_F    28    fraction bits of SVM score (score W = FEA_I+FEA_F, two's complement)
//   SW_W     11    slide-window index width
//   SW_LAST  1199  sw_id of last window in a frame
//   DEPTH    16    FIFO entries, power of 2
//   AW       4     log2(DEPTH)
// PORTS
//   clk         in   1        clock
//   rst         in   1        asynchronous, active-low reset
//   i_valid     in   1        SVM result valid (one window per pulse)
//   is_person   in   1        window classified positive
//   result      in   W        signed SVM score
//   sw_id       in   SW_W     window index
//   rd_en       in   1        pop FIFO head (ignored when empty)
//   frame_ack   in   1        host acknowledges frame_done; clears sticky flags
//   rd_data     out  SW_W+W   head entry {sw_id,result}; valid when !empty
//   empty       out  1        FIFO empty
//   full        out  1        FIFO full
//   count       out  AW+1     FIFO occupancy 0..DEPTH
//   frame_done  out  1        level: last window of frame processed
//   det_total   out  SW_W+1   positives in current/last frame (incl. dropped)
//   best_score  out  W        max score of frame, signed
//   best_id     out  SW_W     sw_id of best_score
//   overflow    out  1        sticky: positive dropped because FIFO full
//   lost        out  1        sticky: i_valid arrived in IDLE(sw_id!=0) or DONE
// BEHAVIOUR
//   Reset (rst=0, async): FIFO ptrs/count=0, empty=1, full=0, state=IDLE, frame_done=0, det_total=0,
//     best_score={1'b1,{W-1{0}}} (most negative), best_id=0, overflow=0, lost=0. rd_data undefined.
//   FSM IDLE -> RUN -> DONE -> IDLE:
//     IDLE: i_valid && sw_id==0 -> RUN; stats cleared and this window processed same cycle.
//           i_valid && sw_id!=0 -> ignored, lost<=1.
//     RUN:  every i_valid processed; if sw_id==SW_LAST -> DONE (window still processed).
//           i_valid && sw_id==0 in RUN -> restart: stats cleared, window processed, stay RUN.
//     DONE: frame_done=1; stats frozen; i_valid ignored, lost<=1; frame_ack -> IDLE next cycle.
//   Processing a window: if is_person: det_total+=1 (saturates at all-ones), push {sw_id,result}.
//     Best update on every processed window (positive or not): if $signed(result)>best_score, latch
//     result/sw_id; ties keep earlier window. Stat clear + first window in same cycle -> stats = that window.
//   FIFO: write registered; entry visible on rd_data/empty deasserted cycle after i_valid.
//     Push when !full, or full && rd_en same cycle (pop+push, count unchanged).
//     Push when full && !rd_en: dropped, overflow<=1, det_total still increments.
//     rd_en when empty: no effect. Simultaneous push+pop when not empty: count unchanged.
//     Pointers AW bits wrap modulo DEPTH; count distinguishes full/empty.
//   frame_ack clears overflow and lost in any state; FIFO contents never cleared except by reset.
//   Outputs all registered except rd_data (memory read at head ptr). No backpressure to SVM.
//   Reset mid-frame: everything returns to reset values; FIFO contents discarded.
// TESTING
//   1. Reset, windows 0..SW_LAST all negative, scores -1.0 .. -0.5 ascending -> empty=1, det_total=0,
//      best_id=SW_LAST, frame_done=1 cycle after last i_valid.
//   2. Positives at sw_id 5,17,300 (scores 0.25,0.75,0.75) -> FIFO pops return 5,17,300 in order,
//      det_total=3, best_score=0.75, best_id=17 (tie keeps earlier).
//   3. DEPTH+3 positives with no rd_en -> full=1, count=DEPTH, overflow=1, det_total=DEPTH+3,
//      popped entries = first DEPTH pushed.
//   4. Full FIFO, rd_en and positive i_valid same cycle -> count stays DEPTH, overflow stays 0,
//      new entry appears at tail.
//   5. In DONE, extra i_valid -> ignored, lost=1; frame_ack -> IDLE, lost=0, overflow=0;
//      next sw_id==0 restarts stats.
//   6. Assert rst low mid-frame with 4 entries queued -> immediate empty=1, count=0,
//      best_score=0x80000000, state IDLE.

Source files
------------

// File: rtl/det_collector.sv
// Per-frame SVM detection collector: show-ahead FIFO of positive windows
// plus frame statistics (positive count, best score and its window id).
module det_collector #(
  parameter int FEA_I   = 4,
  parameter int FEA_F   = 28,
  parameter int SW_W    = 11,
  parameter int SW_LAST = 1199,
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  localparam int W      = FEA_I + FEA_F
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_valid,
  input  logic                is_person,
  input  logic [W-1:0]        result,
  input  logic [SW_W-1:0]     sw_id,
  input  logic                rd_en,
  input  logic                frame_ack,
  output logic [SW_W+W-1:0]   rd_data,
  output logic                empty,
  output logic                full,
  output logic [AW:0]         count,
  output logic                frame_done,
  output logic [SW_W:0]       det_total,
  output logic [W-1:0]        best_score,
  output logic [SW_W-1:0]     best_id,
  output logic                overflow,
  output logic                lost
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [SW_W-1:0] LAST_ID  = SW_LAST[SW_W-1:0];
  localparam logic [AW:0]     FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [W-1:0]    MIN_SC   = {1'b1, {(W-1){1'b0}}};

  state_t              state_q;
  logic                done_q;
  logic                ovf_q;
  logic                lost_q;
  logic [SW_W:0]       tot_q, tot_d;
  logic [W-1:0]        best_q, best_d;
  logic [SW_W-1:0]     bid_q, bid_d;
  logic [AW-1:0]       wr_q, rd_q;
  logic [AW:0]         cnt_q, cnt_d;
  logic                full_q, empty_q;
  logic [SW_W+W-1:0]   mem_q [DEPTH];

  logic                first, last;
  logic                proc, clr, ign;
  logic                push_req, push, pop, drop;
  logic [SW_W:0]       base_tot;
  logic [W-1:0]        base_best;
  logic [SW_W-1:0]     base_bid;

  assign first = (sw_id == '0);
  assign last  = (sw_id == LAST_ID);

  // A window counts in IDLE only when it starts a frame, always in RUN.
  assign proc = i_valid &&
                ((state_q == S_IDLE && first) ||
                 (state_q == S_RUN));
  assign clr  = proc && first;
  assign ign  = i_valid && !proc;

  assign push_req = proc && is_person;
  assign pop      = rd_en && !empty_q;
  assign push     = push_req && (!full_q || rd_en);
  assign drop     = push_req && full_q && !rd_en;

  // Next-state statistics; a restart folds the clear into this window.
  always_comb begin
    base_tot  = clr ? '0 : tot_q;
    base_best = clr ? MIN_SC : best_q;
    base_bid  = clr ? '0 : bid_q;
    tot_d     = base_tot;
    best_d    = base_best;
    bid_d     = base_bid;
    if (push_req && base_tot != '1)
      tot_d = base_tot + 1'b1;
    if (proc && (clr || $signed(result) > $signed(base_best))) begin
      best_d = result;
      bid_d  = sw_id;
    end
  end

  // Occupancy follows the push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Frame FSM with registered frame_done and sticky flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE, S_RUN: begin
          if (proc && last) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (proc) begin
            state_q <= S_RUN;
          end
        end
        S_DONE: begin
          if (frame_ack) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
      if (frame_ack) begin
        ovf_q  <= 1'b0;
        lost_q <= 1'b0;
      end
      if (drop) ovf_q <= 1'b1;
      if (ign)  lost_q <= 1'b1;
    end
  end

  // Statistics registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tot_q  <= '0;
      best_q <= MIN_SC;
      bid_q  <= '0;
    end else begin
      tot_q  <= tot_d;
      best_q <= best_d;
      bid_q  <= bid_d;
    end
  end

  // FIFO pointers and registered flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == FULL_CNT);
      empty_q <= (cnt_d == '0);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= {sw_id, result};
  end

  assign rd_data    = mem_q[rd_q];
  assign empty      = empty_q;
  assign full       = full_q;
  assign count      = cnt_q;
  assign frame_done = done_q;
  assign det_total  = tot_q;
  assign best_score = best_q;
  assign best_id    = bid_q;
  assign overflow   = ovf_q;
  assign lost       = lost_q;

endmodule
